shift_op_sequencer: RTL and testbench
=====================================

Name: shift_op_sequencer

Overview:
- Command-driven controller for the m-bit multi-operational shift register.
- Buffers operation commands (opcode, repeat count, load data) in a small FIFO.
- Drives the register's 3-bit op select for exactly the commanded number of cycles, then holds the register and captures its parallel output as the result.
- Sits between a host or test controller and the shift register, so the register never sees a non-HOLD select outside a command window.

Parameters:
- WIDTH, 10: register width in bits (two 5-bit sub-registers).
- CNT_W, 4: width of the repeat count field.
- FIFO_DEPTH, 4: command FIFO depth (power of two, at least 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; high when the FIFO is not full
- cmd_op  in  3  opcode, encoded per the package
- cmd_count  in  CNT_W  number of op cycles
- cmd_data  in  WIDTH  parallel load value, used by OP_LOAD only
- sel  out  3  op select to the shift register
- load_data  out  WIDTH  parallel value presented to the register inputs
- reg_q  in  WIDTH  register parallel outputs
- result  out  WIDTH  captured register value
- done  out  1  one-cycle pulse; result updated
- busy  out  1  FSM not IDLE, or FIFO not empty

Behaviour:
- Reset (asynchronous, active-high), effective immediately:
  - sel = OP_HOLD, load_data = 0, result = 0, done = 0, busy = 0.
  - FIFO emptied; FSM goes to IDLE.
  - Reset during RUN aborts the command with no done pulse.
- Handshake:
  - A command is pushed on a clk edge when cmd_valid && cmd_ready.
  - cmd_ready is derived from the registered full flag, so there is no push when full.
  - cmd_* must be stable only in the accepting cycle.
- FSM states:
  - IDLE: sel = OP_HOLD. If the FIFO is not empty, pop, latch op/count/data, and go to RUN. If the effective count is 0, go directly to SETTLE.
  - RUN: sel = latched op, load_data = latched data. The down-counter starts at the effective count and decrements each edge; on the edge where it reaches 1, go to SETTLE.
  - SETTLE: sel = OP_HOLD. On exit, result <= reg_q; done pulses in the following cycle; return to IDLE.
- Effective count:
  - OP_LOAD and OP_CLEAR always use 1, regardless of cmd_count.
  - OP_HOLD uses cmd_count, with sel held at HOLD throughout.
  - Other ops use cmd_count; 0 means no op cycles, but done still pulses.
- Latency: a command accepted at edge T with N cycles
  - is popped at edge T+1;
  - drives sel = op during cycles T+2 .. T+1+N;
  - is in SETTLE at T+2+N;
  - asserts done during cycle T+3+N.
  - Back-to-back commands therefore carry 2 HOLD cycles between them (SETTLE plus IDLE).
- Simultaneous push and pop while not full is allowed; occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; the occupancy counter is CLOG2(FIFO_DEPTH)+1 bits.
- result holds its value until the next done.

Optional Feature:
- SHIFT_SEQ_ABORT_EN adds the input port abort (1 bit).
- With the macro: abort high at a clk edge
  - forces the FSM to IDLE and flushes the FIFO;
  - drives sel = OP_HOLD from the next cycle;
  - produces no done pulse and leaves result unchanged.
  - abort has priority over a push in the same cycle: the push is dropped and cmd_ready is low while abort is high.
- Without the macro: the port is absent and commands always run to completion.

Decomposition:
- Package shift_op_pkg:
  - opcode localparams: OP_HOLD = 3'b000, OP_SHR = 3'b001, OP_SHL = 3'b010, OP_ROR = 3'b011, OP_ROL = 3'b100, OP_LOAD = 3'b101, OP_CLEAR = 3'b110, OP_CMPL = 3'b111;
  - FSM state encodings IDLE/RUN/SETTLE;
  - a function returning the effective count.
- One sub-module, shift_cmd_fifo: synchronous FIFO parameterized by data width (3+CNT_W+WIDTH) and depth, with full/empty flags.

Test Plan:
- Reset mid-RUN: assert rst 2 cycles into an OP_SHR count 5 command -> sel = 000 immediately, FIFO empty, result = 0, no done pulse.
- Load then shift: push OP_LOAD data 10'h2B5, then OP_SHL count 3 -> sel = 101 for exactly 1 cycle; sel = 010 for exactly 3 cycles; two done pulses; second result matches the register model (10'h1A8 for logical shift left).
- Latency and count 0: push OP_ROR count 0 at edge T -> sel never 011; done high at cycle T+3.
- Back-to-back and full FIFO: push 5 commands with cmd_valid held high -> cmd_ready low after 4 accepted; 5th accepted after the first pop; the FIFO-limited push order shows in sel; exactly 2 HOLD cycles between op windows.
- OP_CLEAR count 9 -> exactly 1 cycle of sel = 110; result = 0.
- SHIFT_SEQ_ABORT_EN build: abort during RUN of OP_ROL count 8 with 2 commands queued -> sel = 000 the next cycle, busy low 1 cycle later, no done, result unchanged.

Source files
------------

// File: rtl/shift_op_sequencer_pkg.sv
// ============================================================================
// Module   : shift_op_pkg
// Brief    : Opcodes, FSM states and effective-count helper for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shift_op_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_HOLD  = 3'b000;
    localparam op_t OP_SHR   = 3'b001;
    localparam op_t OP_SHL   = 3'b010;
    localparam op_t OP_ROR   = 3'b011;
    localparam op_t OP_ROL   = 3'b100;
    localparam op_t OP_LOAD  = 3'b101;
    localparam op_t OP_CLEAR = 3'b110;
    localparam op_t OP_CMPL  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // LOAD and CLEAR are idempotent, so a single cycle is all they ever need.
    function automatic int unsigned eff_count(input op_t op, input int unsigned count);
        if (op == OP_LOAD || op == OP_CLEAR) begin
            return 32'd1;
        end
        return count;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_op_sequencer_if.sv
// ============================================================================
// Module   : shift_op_sequencer_if
// Brief    : Command handshake plus shift-register control/observe bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shift_op_sequencer_if
    import shift_op_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    op_t              sel;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data, reg_q,
        input  cmd_ready, sel, load_data, result, done, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data, reg_q,
        output cmd_ready, sel, load_data, result, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/shift_op_sequencer_cmd_fifo.sv
// ============================================================================
// Module   : shift_cmd_fifo
// Brief    : Synchronous first-word-fall-through FIFO with registered flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_cmd_fifo #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic [DATA_W-1:0] wdata,
    output logic      [DATA_W-1:0] rdata,
    output logic                   full,
    output logic                   empty
);
    localparam int               c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_DEPTH   = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]    c_CNT_ONE = (c_AW+1)'(1);
    localparam logic [c_AW-1:0]  c_PTR_ONE = c_AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_do_push;
    logic              w_do_pop;
    logic [c_AW:0]     w_count_nxt;

    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage needs no reset: the flags guard every read.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/shift_op_sequencer.sv
// ============================================================================
// Module   : shift_op_sequencer
// Brief    : Queues shift-register commands and drives the op select for
//            exactly the commanded cycle count, then captures the result.
//            Optional SHIFT_SEQ_ABORT_EN adds an abort input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_op_sequencer
    import shift_op_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
`ifdef SHIFT_SEQ_ABORT_EN
    input  wire logic            abort,
`endif
    shift_op_sequencer_if.slave  bus
);
    localparam int               c_PKT_W   = 3 + CNT_W + WIDTH;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic               w_abort;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_PKT_W-1:0] w_wdata;
    logic [c_PKT_W-1:0] w_rdata;
    op_t                w_rd_op;
    logic [CNT_W-1:0]   w_rd_count;
    logic [WIDTH-1:0]   w_rd_data;
    logic [CNT_W-1:0]   w_eff;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    op_t                r_sel;
    logic [WIDTH-1:0]   r_load;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_push  = bus.cmd_valid && !w_full && !w_abort;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty && !w_abort;
    assign w_wdata = {bus.cmd_op, bus.cmd_count, bus.cmd_data};

    shift_cmd_fifo #(
        .DATA_W (c_PKT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_abort),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_rd_op    = w_rdata[c_PKT_W-1 -: 3];
    assign w_rd_count = w_rdata[WIDTH +: CNT_W];
    assign w_rd_data  = w_rdata[WIDTH-1:0];
    assign w_eff      = CNT_W'(eff_count(w_rd_op, 32'(w_rd_count)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= OP_HOLD;
            r_load   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_sel   <= OP_HOLD;
            r_load  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cnt <= w_eff;
                        if (w_eff == '0) begin
                            r_state <= ST_SETTLE;
                            r_sel   <= OP_HOLD;
                        end else begin
                            r_state <= ST_RUN;
                            r_sel   <= w_rd_op;
                            r_load  <= w_rd_data;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= ST_SETTLE;
                        r_sel   <= OP_HOLD;
                        r_load  <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    // Register has been held for one cycle, so reg_q is final.
                    r_result <= bus.reg_q;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= OP_HOLD;
                end
            endcase
        end
    end

    assign bus.cmd_ready = !w_full && !w_abort;
    assign bus.sel       = r_sel;
    assign bus.load_data = r_load;
    assign bus.result    = r_result;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_shift_op_sequencer.sv
// ============================================================================
// Module   : tb_shift_op_sequencer
// Brief    : Directed scoreboard bench for shift_op_sequencer with a
//            behavioural shift register on reg_q.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_op_sequencer;
    import shift_op_pkg::*;

    localparam int WIDTH      = 10;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    shift_op_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_op_sequencer #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] model_q;
    always @(posedge clk or posedge rst) begin
        if (rst) model_q <= '0;
        else begin
            case (bus.sel)
                OP_SHR:   model_q <= model_q >> 1;
                OP_SHL:   model_q <= model_q << 1;
                OP_ROR:   model_q <= {model_q[0], model_q[WIDTH-1:1]};
                OP_ROL:   model_q <= {model_q[WIDTH-2:0], model_q[WIDTH-1]};
                OP_LOAD:  model_q <= bus.load_data;
                OP_CLEAR: model_q <= '0;
                OP_CMPL:  model_q <= ~model_q;
                default:  model_q <= model_q;
            endcase
        end
    end
    assign bus.reg_q = model_q;

    int passed = 0;
    int total  = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] len;
    } run_t;

    int               sel_cnt [8];
    int               done_cnt = 0;
    int               last_done_edge = 0;
    run_t             run_q [$];
    logic [2:0]       run_sel = OP_HOLD;
    int               run_len = 0;
    logic [WIDTH-1:0] exp_q [$];

    logic [2:0] exp_op  [11] = '{OP_SHR, OP_HOLD, OP_ROL, OP_HOLD, OP_CMPL, OP_HOLD,
                                 OP_SHL, OP_HOLD, OP_ROR, OP_HOLD, OP_SHR};
    int         exp_len [11] = '{3, 2, 2, 2, 1, 2, 1, 2, 2, 2, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string info);
        total++;
        $display("FAIL %s: %s", name, info);
    endtask

    // Monitor: sel statistics, op-window run lengths, and result scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            run_t tmp;
            sel_cnt[bus.sel]++;
            if (bus.sel == run_sel) run_len++;
            else begin
                tmp.op  = run_sel;
                tmp.len = 16'(run_len);
                run_q.push_back(tmp);
                run_sel = bus.sel;
                run_len = 1;
            end
            if (bus.done) begin
                done_cnt++;
                last_done_edge = edge_n;
                if (exp_q.size() == 0) fail("unexpected_done", $sformatf("result 0x%0h", bus.result));
                else check("result", 32'(bus.result), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input logic [2:0] op, input int cnt, input logic [WIDTH-1:0] d,
                        input bit has_exp, input logic [WIDTH-1:0] exp, output int acc);
        int g = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_count = CNT_W'(cnt);
        bus.cmd_data  = d;
        while (!bus.cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) fail("push_timeout", "cmd_ready never rose");
        if (has_exp) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc = edge_n;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (bus.busy && g < 300);
        if (bus.busy) fail(name, "busy did not fall");
        @(negedge clk);
    endtask

    task automatic wait_sel(input logic [2:0] op, input string name);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (bus.sel != op && g < 50);
        if (bus.sel != op) fail(name, "op window never started");
    endtask

    initial begin
        int t;
        int a [6];
        int s, snap, base;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_HOLD;
        bus.cmd_count = '0;
        bus.cmd_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_sel", 32'(bus.sel), 32'(OP_HOLD));
        check("rst_load_data", 32'(bus.load_data), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        rst = 1'b0;

        // Reset two cycles into an SHR count 5 window
        push(OP_SHR, 5, '0, 1'b0, '0, t);
        wait_sel(OP_SHR, "midrun_start");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_sel", 32'(bus.sel), 32'(OP_HOLD));
        check("midrun_busy", 32'(bus.busy), 0);
        check("midrun_result", 32'(bus.result), 0);
        snap = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun_no_done", 32'(done_cnt), 32'(snap));

        // LOAD ignores its count; SHL 3 of 0x2B5 gives 0x1A8
        s = sel_cnt[OP_LOAD];
        base = sel_cnt[OP_SHL];
        snap = done_cnt;
        push(OP_LOAD, 7, 10'h2B5, 1'b1, 10'h2B5, t);
        push(OP_SHL, 3, 10'h000, 1'b1, 10'h1A8, t);
        wait_idle("load_shift_idle");
        check("load_cycles", 32'(sel_cnt[OP_LOAD] - s), 1);
        check("shl_cycles", 32'(sel_cnt[OP_SHL] - base), 3);
        check("load_shift_dones", 32'(done_cnt - snap), 2);

        // Count 0: no op cycles, done seen right after edge T+2
        s = sel_cnt[OP_ROR];
        push(OP_ROR, 0, 10'h000, 1'b1, 10'h1A8, t);
        wait_idle("cnt0_idle");
        check("cnt0_done_edge", 32'(last_done_edge), 32'(t + 2));
        check("cnt0_no_ror", 32'(sel_cnt[OP_ROR] - s), 0);

        // Back-to-back until full, then a sixth held off until the second pop
        base = run_q.size();
        snap = done_cnt;
        push(OP_SHR,  3, 10'h000, 1'b1, 10'h035, a[0]);
        push(OP_ROL,  2, 10'h000, 1'b1, 10'h0D4, a[1]);
        push(OP_CMPL, 1, 10'h000, 1'b1, 10'h32B, a[2]);
        push(OP_SHL,  1, 10'h000, 1'b1, 10'h256, a[3]);
        push(OP_ROR,  2, 10'h000, 1'b1, 10'h295, a[4]);
        check("full_ready_low", 32'(bus.cmd_ready), 0);
        check("b2b_accept_span", 32'(a[4] - a[0]), 4);
        push(OP_SHR,  1, 10'h000, 1'b1, 10'h14A, a[5]);
        check("full_accept_edge", 32'(a[5] - a[0]), 7);
        wait_idle("b2b_idle");
        check("b2b_dones", 32'(done_cnt - snap), 6);
        if (run_q.size() < base + 12) fail("b2b_runs", $sformatf("only %0d windows", run_q.size() - base));
        else begin
            for (int i = 0; i < 11; i++) begin
                check($sformatf("run%0d_op", i), 32'(run_q[base+1+i].op), 32'(exp_op[i]));
                check($sformatf("run%0d_len", i), 32'(run_q[base+1+i].len), 32'(exp_len[i]));
            end
        end

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort a ROL 8 window with two commands queued behind it
        snap = done_cnt;
        push(OP_ROL, 8, 10'h000, 1'b0, '0, t);
        push(OP_SHR, 2, 10'h000, 1'b0, '0, t);
        push(OP_SHL, 2, 10'h000, 1'b0, '0, t);
        wait_sel(OP_ROL, "abort_start");
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_ready_low", 32'(bus.cmd_ready), 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_sel", 32'(bus.sel), 32'(OP_HOLD));
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 0);
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - snap), 0);
        check("abort_result", 32'(bus.result), 32'h14A);
`endif

        // CLEAR ignores count 9
        s = sel_cnt[OP_CLEAR];
        push(OP_CLEAR, 9, 10'h3FF, 1'b1, 10'h000, t);
        wait_idle("clear_idle");
        check("clear_cycles", 32'(sel_cnt[OP_CLEAR] - s), 1);
        check("clear_result", 32'(bus.result), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
